// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM state
// encodings and the byte-lane geometry of one instruction word.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_HDR   = 3'd0,
    ST_DATA  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CHK   = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_e;

  localparam int LANES  = 4;
  localparam int LANE_W = $clog2(LANES);

endpackage

// File: rtl/imem_loader_word_packer.sv
// Little-endian word assembler: byte k of a word lands in bits [8k+7:8k].
// word_out already includes the byte being pushed this cycle, so the top
// level can register the complete word on the same edge as the 4th byte.
module word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        push,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_out,
  output logic        full
);

  logic [LANE_W-1:0] lane_q, lane_d;
  logic [31:0]       word_q, word_d;

  // Next lane / word: clear on a new image, otherwise merge the pushed byte.
  always_comb begin
    lane_d = lane_q;
    word_d = word_q;
    if (clr) begin
      lane_d = '0;
      word_d = '0;
    end else if (push) begin
      word_d[{lane_q, 3'b000} +: 8] = byte_in;
      lane_d = lane_q + LANE_W'(1);
    end
  end

  // Lane counter and assembly register; a partial word is dropped on reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lane_q <= '0;
      word_q <= '0;
    end else begin
      lane_q <= lane_d;
      word_q <= word_d;
    end
  end

  assign word_out = word_d;
  assign full     = push && (lane_q == LANE_W'(LANES - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader for the instruction memory. Consumes header (word count),
// payload and an 8-bit additive checksum over the payload, writes words from
// address 0 upward and releases cpu_hold only after a matching checksum.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic              start,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [8:0]      DEPTH_B = 9'(DEPTH);
  localparam logic [ADDR_W:0] N_ONE   = 1;

  state_e              state_q;
  logic [ADDR_W:0]     n_q;
  logic [ADDR_W-1:0]   word_addr_q;
  logic [7:0]          csum_q;
  logic                we_q;
  logic [ADDR_W-1:0]   waddr_q;
  logic [31:0]         wdata_q;
  logic                hold_q;
  logic                done_q;
  logic                error_q;

  logic                accept;
  logic                hdr_ok;
  logic                last_word;
  logic                pack_clr;
  logic                pack_push;
  logic                pack_full;
  logic [31:0]         pack_word;

  // Ready is a pure decode of the state, held low while reset is asserted.
  always_comb begin
    byte_ready = 1'b0;
    if (reset) begin
      case (state_q)
        ST_HDR, ST_DATA, ST_CHK: byte_ready = 1'b1;
        default:                 byte_ready = 1'b0;
      endcase
    end
  end

  assign accept    = byte_valid && byte_ready;
  assign hdr_ok    = (byte_data != 8'd0) && ({1'b0, byte_data} <= DEPTH_B);
  assign last_word = ({1'b0, word_addr_q} == (n_q - N_ONE));
  assign pack_clr  = accept && (state_q == ST_HDR);
  assign pack_push = accept && (state_q == ST_DATA);

  word_packer u_packer (
    .clk      (clk),
    .reset    (reset),
    .clr      (pack_clr),
    .push     (pack_push),
    .byte_in  (byte_data),
    .word_out (pack_word),
    .full     (pack_full)
  );

  // Load sequencer with registered memory-port and status outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_HDR;
      n_q         <= '0;
      word_addr_q <= '0;
      csum_q      <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      hold_q      <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        ST_HDR: begin
          if (accept) begin
            if (hdr_ok) begin
              n_q         <= byte_data[ADDR_W:0];
              word_addr_q <= '0;
              csum_q      <= '0;
              state_q     <= ST_DATA;
            end else begin
              error_q <= 1'b1;
              hold_q  <= 1'b1;
              state_q <= ST_ERR;
            end
          end
        end
        ST_DATA: begin
          if (accept) begin
            csum_q <= csum_q + byte_data;
            if (pack_full) begin
              we_q    <= 1'b1;
              waddr_q <= word_addr_q;
              wdata_q <= pack_word;
              state_q <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          // word_addr stops at N-1, so an N==DEPTH image never wraps.
          if (last_word) begin
            state_q <= ST_CHK;
          end else begin
            word_addr_q <= word_addr_q + ADDR_W'(1);
            state_q     <= ST_DATA;
          end
        end
        ST_CHK: begin
          if (accept) begin
            if (byte_data == csum_q) begin
              done_q  <= 1'b1;
              hold_q  <= 1'b0;
              state_q <= ST_DONE;
            end else begin
              error_q <= 1'b1;
              hold_q  <= 1'b1;
              state_q <= ST_ERR;
            end
          end
        end
        ST_DONE, ST_ERR: begin
          if (start) begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            hold_q  <= 1'b1;
            state_q <= ST_HDR;
          end
        end
        default: begin
          done_q  <= 1'b0;
          error_q <= 1'b0;
          hold_q  <= 1'b1;
          state_q <= ST_HDR;
        end
      endcase
    end
  end

  assign we       = we_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign cpu_hold = hold_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule
